// File: rtl/lru_matrix_tracker.sv
// Matrix-based true-LRU tracker for one WAYS-way set, with per-way valid bits and invalidation.
// Optional way locking is compiled in when LRU_LOCK_EN is defined.
module lru_matrix_tracker #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [WAY_W-1:0] access1_i,
    input  logic             v1_i,
    input  logic [WAY_W-1:0] access2_i,
    input  logic             v2_i,
    input  logic             inv_i,
    input  logic [WAY_W-1:0] inv_way_i,
    input  logic [WAYS-1:0]  lock_mask_i,
    output logic [WAY_W-1:0] replace_which_o,
    output logic             replace_v_o,
    output logic [WAYS-1:0]  valid_o
);

    // m_q[i][j] = 1 : way i used more recently than way j; diagonal never set
    logic [WAYS-1:0][WAYS-1:0] m_q, m_d;
    logic [WAYS-1:0]           valid_q, valid_d;
    logic [WAYS-1:0]           inv_hit, hit1, hit2;
    logic [WAYS-1:0]           cand, free, oldest, pick;

    // Out-of-range indices decode to no hit, so they leave the state untouched
    always_comb begin
        inv_hit = '0;
        hit1    = '0;
        hit2    = '0;
        for (int k = 0; k < WAYS; k++) begin
            inv_hit[k] = inv_i && (inv_way_i == WAY_W'(k));
            hit1[k]    = v1_i  && (access1_i == WAY_W'(k));
            hit2[k]    = v2_i  && (access2_i == WAY_W'(k));
        end
    end

    // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
    // Updates are applied in order: invalidate, port 1, port 2 -- later ones win.
    always_comb begin
        m_d     = m_q;
        valid_d = valid_q;
        for (int k = 0; k < WAYS; k++) begin
            if (inv_hit[k]) begin
                for (int j = 0; j < WAYS; j++) begin
                    m_d[k][j] = 1'b0;
                    m_d[j][k] = (j != k);
                end
                valid_d[k] = 1'b0;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            if (hit1[k]) begin
                for (int j = 0; j < WAYS; j++) begin
                    m_d[k][j] = (j != k);
                    m_d[j][k] = 1'b0;
                end
                valid_d[k] = 1'b1;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            if (hit2[k]) begin
                for (int j = 0; j < WAYS; j++) begin
                    m_d[k][j] = (j != k);
                    m_d[j][k] = 1'b0;
                end
                valid_d[k] = 1'b1;
            end
        end
    end

    // NOTE: the matrix is a handful of flops, not a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            m_q     <= '0;
            valid_q <= '0;
        end else begin
            m_q     <= m_d;
            valid_q <= valid_d;
        end
    end

`ifdef LRU_LOCK_EN
    assign cand        = ~lock_mask_i;
    assign replace_v_o = |cand;
`else
    logic unused_lock;
    assign unused_lock = ^lock_mask_i;
    assign cand        = '1;
    assign replace_v_o = 1'b1;
`endif

    // Invalid candidates take precedence; otherwise pick the candidate older than all others
    always_comb begin
        free = cand & ~valid_q;
        for (int i = 0; i < WAYS; i++) begin
            oldest[i] = cand[i] && ((m_q[i] & cand) == '0);
        end
        pick            = (|free) ? free : oldest;
        replace_which_o = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (pick[i]) replace_which_o = WAY_W'(i);
        end
    end

    assign valid_o = valid_q;

endmodule

// File: tb/tb_lru_matrix_tracker.sv
// Directed self-checking bench for lru_matrix_tracker (WAYS=4); scenario 5 expectations follow LRU_LOCK_EN.
module tb_lru_matrix_tracker;

    localparam int WAYS  = 4;
    localparam int WAY_W = 2;

    logic             clk_i = 1'b0;
    logic             reset_n_i = 1'b1;
    logic [WAY_W-1:0] access1_i = '0;
    logic             v1_i = 1'b0;
    logic [WAY_W-1:0] access2_i = '0;
    logic             v2_i = 1'b0;
    logic             inv_i = 1'b0;
    logic [WAY_W-1:0] inv_way_i = '0;
    logic [WAYS-1:0]  lock_mask_i = '0;
    logic [WAY_W-1:0] replace_which_o;
    logic             replace_v_o;
    logic [WAYS-1:0]  valid_o;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    lru_matrix_tracker #(.WAYS(WAYS)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .access1_i       (access1_i),
        .v1_i            (v1_i),
        .access2_i       (access2_i),
        .v2_i            (v2_i),
        .inv_i           (inv_i),
        .inv_way_i       (inv_way_i),
        .lock_mask_i     (lock_mask_i),
        .replace_which_o (replace_which_o),
        .replace_v_o     (replace_v_o),
        .valid_o         (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [3:0] valid,
                                input logic [1:0] which, input logic v);
        check({tag, ".valid"}, 32'(valid_o), 32'(valid));
        check({tag, ".which"}, 32'(replace_which_o), 32'(which));
        check({tag, ".v"}, 32'(replace_v_o), 32'(v));
    endtask

    // Inputs are driven 1 time unit after a rising edge and outputs sampled at the same point
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        v1_i  = 1'b0;
        v2_i  = 1'b0;
        inv_i = 1'b0;
    endtask

    task automatic touch1(input logic [1:0] way);
        idle();
        v1_i      = 1'b1;
        access1_i = way;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // 1: reset
        #2 reset_n_i = 1'b0;
        #1 expect_state("rst_asserted", 4'b0000, 2'd0, 1'b1);
        tick();
        reset_n_i = 1'b1;
        tick();
        expect_state("rst_released", 4'b0000, 2'd0, 1'b1);

        // 2: fill via port 1, invalid ways are chosen first
        touch1(2'd0);
        expect_state("fill0", 4'b0001, 2'd1, 1'b1);
        touch1(2'd1);
        expect_state("fill1", 4'b0011, 2'd2, 1'b1);
        touch1(2'd2);
        expect_state("fill2", 4'b0111, 2'd3, 1'b1);
        touch1(2'd3);
        expect_state("fill3", 4'b1111, 2'd0, 1'b1);
        touch1(2'd0);
        expect_state("retouch0", 4'b1111, 2'd1, 1'b1);   // order 0,3,2,1

        // 3: both ports in one cycle, port 2 ends MRU
        v1_i = 1'b1; access1_i = 2'd0;
        v2_i = 1'b1; access2_i = 2'd1;
        tick();
        idle();
        expect_state("dual_port", 4'b1111, 2'd2, 1'b1);  // order 1,0,3,2
        touch1(2'd2);
        expect_state("touch2", 4'b1111, 2'd3, 1'b1);     // order 2,1,0,3

        // 4: invalidate, then invalidate + access to the same way
        inv_i = 1'b1; inv_way_i = 2'd1;
        tick();
        idle();
        expect_state("inv1", 4'b1101, 2'd1, 1'b1);
        inv_i = 1'b1; inv_way_i = 2'd1;
        v1_i  = 1'b1; access1_i = 2'd1;
        tick();
        idle();
        expect_state("inv_touch1", 4'b1111, 2'd3, 1'b1); // order 1,2,0,3

        // v1 and v2 on the same way behave as a single touch
        v1_i = 1'b1; access1_i = 2'd3;
        v2_i = 1'b1; access2_i = 2'd3;
        tick();
        idle();
        expect_state("same_way", 4'b1111, 2'd0, 1'b1);   // order 3,1,2,0

        // 5: build order 3,2,1,0 then apply lock masks combinationally
        touch1(2'd1);
        touch1(2'd2);
        touch1(2'd3);
        expect_state("pre_lock", 4'b1111, 2'd0, 1'b1);
        lock_mask_i = 4'b0001;
        #1;
`ifdef LRU_LOCK_EN
        expect_state("lock0001", 4'b1111, 2'd1, 1'b1);
`else
        expect_state("lock0001", 4'b1111, 2'd0, 1'b1);
`endif
        lock_mask_i = 4'b1111;
        #1;
`ifdef LRU_LOCK_EN
        expect_state("lock1111", 4'b1111, 2'd0, 1'b0);
`else
        expect_state("lock1111", 4'b1111, 2'd0, 1'b1);
`endif
        lock_mask_i = 4'b0000;
        #1 expect_state("unlock", 4'b1111, 2'd0, 1'b1);

        // 6: reset dropped mid-cycle during traffic
        v1_i = 1'b1; access1_i = 2'd0;
        v2_i = 1'b1; access2_i = 2'd1;
        tick();
        access1_i = 2'd2; access2_i = 2'd3;
        #3 reset_n_i = 1'b0;
        #1 expect_state("rst_midcycle", 4'b0000, 2'd0, 1'b1);
        tick();
        access1_i = 2'd1; access2_i = 2'd0;
        inv_i = 1'b1; inv_way_i = 2'd2;
        expect_state("rst_traffic1", 4'b0000, 2'd0, 1'b1);
        tick();
        expect_state("rst_traffic2", 4'b0000, 2'd0, 1'b1);
        idle();
        reset_n_i = 1'b1;
        tick();
        expect_state("rst_after", 4'b0000, 2'd0, 1'b1);

        // port 2 alone after reset
        v2_i = 1'b1; access2_i = 2'd2;
        tick();
        idle();
        expect_state("port2_only", 4'b0100, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lru_matrix_tracker.md
# lru_matrix_tracker

Parametrised matrix-based LRU tracker for one set of a WAYS-way cache or lookup table. It replaces the fixed 4-way recorder. It adds:
- configurable way count
- true same-cycle application of both access ports
- per-way valid tracking with invalidation
- optional way locking

It sits beside the tag/data arrays of the SM4 key/round-key cache. It tells the fill path which way to replace next.

## Interface
Parameters:
- WAYS, 4, number of tracked ways; legal 2..16
- WAY_W, $clog2(WAYS), index width; derived, never overridden

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_n_i  in  1  reset; asynchronous, active-low
- access1_i  in  WAY_W  way touched by port 1
- v1_i  in  1  port 1 access valid
- access2_i  in  WAY_W  way touched by port 2
- v2_i  in  1  port 2 access valid
- inv_i  in  1  invalidate request
- inv_way_i  in  WAY_W  way to invalidate
- lock_mask_i  in  WAYS  bit k=1 excludes way k from replacement
- replace_which_o  out  WAY_W  victim way index
- replace_v_o  out  1  victim index is meaningful
- valid_o  out  WAYS  per-way valid bits

## Operation
- State: matrix M[WAYS][WAYS] and valid[WAYS].
  - M[i][j]=1 means way i was used more recently than way j.
  - Diagonal entries are constant 0.
- Access to way k (touch): row k set to all-ones (off-diagonal), column k cleared, valid[k] set.
- Invalidate of way k: row k cleared, column k set (off-diagonal), valid[k] cleared. This makes k the LRU way.
- Same-cycle ordering, applied in one edge: invalidate, then port 1 touch, then port 2 touch.
  - Port 2's way ends as MRU.
  - Access and invalidate to the same way in one cycle: way stays valid and becomes MRU.
  - v1 and v2 to the same way: identical to a single touch.
- An index ≥ WAYS on any port is ignored; the matrix and valid bits are unchanged.
- Victim selection is combinational from the registered state plus lock_mask_i:
  - Candidate set: unlocked ways.
  - If any candidate is invalid, victim = lowest-index invalid candidate.
  - Otherwise victim = lowest-index candidate i with M[i][j]=0 for every candidate j≠i, i.e. the LRU way among candidates.
  - No candidate: replace_v_o=0, replace_which_o=0.
- Reset values: M all 0, valid all 0 → valid_o=0, replace_which_o=0, replace_v_o=1.

## Timing
- Accesses and invalidates sampled in cycle t change M/valid at the edge ending t. They are visible on replace_which_o/valid_o in cycle t+1.
- lock_mask_i affects the outputs in the same cycle (combinational path; no state).
- No handshake; every valid request is accepted every cycle; no stalls.
- reset_n_i low clears all state immediately, independent of clk_i.
  - Outputs show reset values while reset is asserted.
  - Reset dominates any same-cycle access or invalidate.
- Release of reset is synchronised externally.

## Configuration
- LRU_LOCK_EN defined: lock_mask_i participates in victim selection as above.
- LRU_LOCK_EN undefined:
  - lock_mask_i is ignored and treated as all-zero.
  - The port stays in the interface.
  - replace_v_o is constant 1.

## Test plan
WAYS=4; for scenario 5 the bench is built with LRU_LOCK_EN defined.
1. Release reset with no access → replace_which_o=0, replace_v_o=1, valid_o=4'b0000.
2. Port 1 touches ways 0,1,2,3 on consecutive cycles → valid_o=4'b1111 and replace_which_o=0 after the 4th edge. Then touch way 0 → replace_which_o=1 next cycle.
3. After the fill of scenario 2, v1 to way 0 and v2 to way 1 in one cycle → replace_which_o=2. Then touch way 2 → replace_which_o=3.
4. All valid, inv_i to way 1 → valid_o=4'b1101, replace_which_o=1. Then inv_i and v1 both to way 1 in one cycle → valid_o=4'b1111, way 1 is MRU, replace_which_o equals the prior LRU among the other ways.
5. LRU way 0, lock_mask_i=4'b0001 → replace_which_o=1 in the same cycle. lock_mask_i=4'b1111 → replace_v_o=0, replace_which_o=0. Without the macro the same stimulus gives replace_which_o=0, replace_v_o=1.
6. Drop reset_n_i mid-cycle during continuous port-1/port-2 traffic → outputs return to reset values before the next clk_i edge. Traffic during reset has no effect.
